// File: rtl/online_softmax_stage_pkg.sv
// Shared types and defaults for the online-softmax stage.
// The typedefs describe the default configuration; the top derives its port widths from its parameters.
package online_softmax_stage_pkg;

  localparam int INT_WIDTH      = 16;
  localparam int FRAC_W_DEFAULT = 15;
  localparam int SUM_W_DEFAULT  = FRAC_W_DEFAULT + 8;

  typedef logic signed [INT_WIDTH-1:0] int_t;
  typedef logic [FRAC_W_DEFAULT:0]     exp_t;
  typedef logic [SUM_W_DEFAULT-1:0]    sum_t;

  typedef enum logic {
    ROW_START,
    ROW_ACTIVE
  } row_state_e;

endpackage

// File: rtl/online_softmax_stage_pow2_neg.sv
// Saturating 2^-d in Q1.FRAC_W: ONE >> d, or zero once d exceeds FRAC_W.
module pow2_neg #(
  parameter int FRAC_W  = 15,
  parameter int SHIFT_W = 17
) (
  input  logic [SHIFT_W-1:0] shamt,
  output logic [FRAC_W:0]    val
);

  localparam logic [FRAC_W:0] ONE = {1'b1, {FRAC_W{1'b0}}};

  always_comb begin
    val = '0;
    if (shamt <= SHIFT_W'(FRAC_W)) val = ONE >> shamt;
  end

endmodule

// File: rtl/online_softmax_stage.sv
// One step of online softmax: tracks the row max and running denominator,
// emitting p = 2^(s-m) and the rescale factor for earlier accumulators.
module online_softmax_stage
  import online_softmax_stage_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEFAULT,
  parameter int SUM_W  = FRAC_W + 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_in,
  output logic              rdy_out,
  input  int_t              s_in,
  input  logic              last_in,
  output logic              vld_out,
  input  logic              rdy_in,
  output logic [FRAC_W:0]   p_out,
  output logic [FRAC_W:0]   alpha_out,
  output int_t              m_out,
  output logic [SUM_W-1:0]  l_out,
  output logic              last_out
);

  localparam int DIFF_W = INT_WIDTH + 1;
  localparam int PROD_W = SUM_W + FRAC_W + 1;
  localparam logic [FRAC_W:0]  ONE     = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  row_state_e       state_q, state_d;
  logic             vld_q, vld_d, last_q, last_d;
  logic [FRAC_W:0]  p_q, p_d, alpha_q, alpha_d;
  int_t             m_q, m_d;
  logic [SUM_W-1:0] l_q, l_d;

  logic                     accept, is_first;
  int_t                     m_max;
  logic signed [DIFF_W-1:0] d_p, d_a;
  logic [FRAC_W:0]          p_shift, alpha_shift, p_new, alpha_new;
  logic [PROD_W-1:0]        prod;
  logic [SUM_W:0]           l_sum;
  logic [SUM_W-1:0]         l_new;

  assign rdy_out  = !vld_q || rdy_in;
  assign accept   = vld_in && rdy_out;
  assign is_first = (state_q == ROW_START);

  // The output registers double as the row state, so m/l only move on acceptance.
  assign m_max = (s_in > m_q) ? s_in : m_q;
  assign d_p   = $signed({m_max[INT_WIDTH-1], m_max}) - $signed({s_in[INT_WIDTH-1], s_in});
  assign d_a   = $signed({m_max[INT_WIDTH-1], m_max}) - $signed({m_q[INT_WIDTH-1], m_q});

  pow2_neg #(.FRAC_W(FRAC_W), .SHIFT_W(DIFF_W)) u_pow2_p (
    .shamt ($unsigned(d_p)),
    .val   (p_shift)
  );

  pow2_neg #(.FRAC_W(FRAC_W), .SHIFT_W(DIFF_W)) u_pow2_alpha (
    .shamt ($unsigned(d_a)),
    .val   (alpha_shift)
  );

  assign p_new     = is_first ? ONE : p_shift;
  assign alpha_new = is_first ? '0  : alpha_shift;
  assign prod      = PROD_W'(l_q) * PROD_W'(alpha_new);
  assign l_sum     = {1'b0, prod[FRAC_W +: SUM_W]} + (SUM_W+1)'(p_new);
  assign l_new     = is_first ? SUM_W'(ONE) : (l_sum[SUM_W] ? SUM_MAX : l_sum[SUM_W-1:0]);

  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a variable unassigned (no latches).
    state_d = state_q;
    vld_d   = vld_q;
    p_d     = p_q;
    alpha_d = alpha_q;
    m_d     = m_q;
    l_d     = l_q;
    last_d  = last_q;
    if (accept) begin
      vld_d   = 1'b1;
      p_d     = p_new;
      alpha_d = alpha_new;
      m_d     = is_first ? s_in : m_max;
      l_d     = l_new;
      last_d  = last_in;
      state_d = last_in ? ROW_START : ROW_ACTIVE;
    end else if (rdy_in) begin
      vld_d = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ROW_START;
      vld_q   <= 1'b0;
      p_q     <= '0;
      alpha_q <= '0;
      m_q     <= '0;
      l_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      p_q     <= p_d;
      alpha_q <= alpha_d;
      m_q     <= m_d;
      l_q     <= l_d;
      last_q  <= last_d;
    end
  end

  assign vld_out   = vld_q;
  assign p_out     = p_q;
  assign alpha_out = alpha_q;
  assign m_out     = m_q;
  assign l_out     = l_q;
  assign last_out  = last_q;

endmodule

// File: doc/online_softmax_stage.md
ONLINE_SOFTMAX_STAGE -- requirements
Module: online_softmax_stage

Interface
REQ-001 SHALL have parameter FRAC_W, default 15, giving the fraction bits of probability/rescale values (ONE = 2^FRAC_W).
REQ-002 SHALL have parameter SUM_W, default FRAC_W+8, giving the width of the running-sum output.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port vld_in, input, 1, upstream score valid.
REQ-006 SHALL have port rdy_out, output, 1, stage ready to accept a score.
REQ-007 SHALL have port s_in, input, INT_T, scaled score from the dot-product stage.
REQ-008 SHALL have port last_in, input, 1, marking the final score of a query row.
REQ-009 SHALL have port vld_out, output, 1, output beat valid.
REQ-010 SHALL have port rdy_in, input, 1, downstream ready.
REQ-011 SHALL have port p_out, output, EXP_T, 2^(s-m_new) in Q1.FRAC_W.
REQ-012 SHALL have port alpha_out, output, EXP_T, rescale 2^(m_old-m_new) for prior accumulators, in Q1.FRAC_W.
REQ-013 SHALL have port m_out, output, INT_T, running row maximum after this score.
REQ-014 SHALL have port l_out, output, SUM_T, running denominator after this score.
REQ-015 SHALL have port last_out, output, 1, registered copy of last_in.

Function
REQ-016 SHALL accept a score when vld_in && rdy_out; rdy_out SHALL equal !vld_out || rdy_in.
REQ-017 SHALL present results for an accepted score on the next clock edge (latency 1), full throughput of one score per cycle.
REQ-018 SHALL hold all outputs stable while vld_out && !rdy_in.
REQ-019 SHALL clear vld_out when rdy_in is high and no score is accepted.
REQ-020 SHALL use a two-state FSM: ROW_START (no score of the current row seen) and ROW_ACTIVE.
REQ-021 ROW_START -> ROW_ACTIVE on acceptance with !last_in; any state -> ROW_START on acceptance with last_in; otherwise the state SHALL hold.
REQ-022 On the first score of a row: m_new = s, p = ONE, alpha = 0, l = ONE.
REQ-023 On later scores: m_new = max(m_old, s); d_p = m_new - s; d_a = m_new - m_old, each computed at INT_WIDTH+1 signed bits (never negative).
REQ-024 p = ONE >> d_p and alpha = ONE >> d_a; a shift amount > FRAC_W SHALL yield 0.
REQ-025 l_new = ((l_old * alpha) >> FRAC_W) + p, truncating, saturating at 2^SUM_W - 1.
REQ-026 A single score with last_in in ROW_START SHALL be treated as first-of-row and return the FSM to ROW_START.
REQ-027 Row state (m, l) SHALL update only on acceptance, never during stalls.

Reset
REQ-028 On rst: vld_out=0, p_out=0, alpha_out=0, m_out=0, l_out=0, last_out=0, FSM=ROW_START, internal m and l = 0.
REQ-029 Reset asserted mid-row SHALL discard the partial row; the next accepted score SHALL be first-of-row.

Structure
REQ-030 FRAC_W default, EXP_T (FRAC_W+1 bits, unsigned) and SUM_T (SUM_W bits, unsigned) SHALL live in the shared package beside INT_T/INT_WIDTH.
REQ-031 The saturating 2^-d shifter SHALL be one combinational sub-module, pow2_neg, instantiated twice (p and alpha).

Verification (FRAC_W=15, ONE=32768)
REQ-032 Row [5, last] -> p=32768, alpha=0, m=5, l=32768, last_out=1.
REQ-033 Row [4, 6 last] -> beat2: m=6, alpha=8192, p=32768, l=40960.
REQ-034 Row [6, 4 last] -> beat2: m=6, alpha=32768, p=8192, l=40960.
REQ-035 Row [0, -20 last] -> beat2: p=0, alpha=32768, l=32768 (shift saturation).
REQ-036 Row [1,2,3 last] with rdy_in low for 3 cycles after beat1 -> rdy_out=0 and beat1 outputs stable during stall; beats 2/3 give l=49152, l=57344; no beat lost or duplicated.
REQ-037 Row [3, 7], assert rst after beat2, then row [2, last] -> all outputs 0 during reset; the new beat gives m=2, p=32768, l=32768, alpha=0.
